// File: rtl/hft_pkg.sv
// Shared market-data types for the top-of-book and volatility blocks.
package hft_pkg;

  localparam int PRICE_W = 32;

  typedef enum logic {SIDE_BID = 1'b0, SIDE_ASK = 1'b1} side_e;
  typedef logic [PRICE_W-1:0] price_t;

endpackage

// File: rtl/best_price_tracker_tob_regfile.sv
// Per-stock top-of-book storage: best bid/ask with presence flags plus the last emitted pair.
module tob_regfile
  import hft_pkg::*;
#(
  parameter int NUM_STOCKS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_W       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_W-1:0]       rd_id,
  output logic [DATA_WIDTH-1:0] rd_bid,
  output logic [DATA_WIDTH-1:0] rd_ask,
  output logic                  rd_bid_vld,
  output logic                  rd_ask_vld,
  output logic [DATA_WIDTH-1:0] rd_last_ask,
  output logic [DATA_WIDTH-1:0] rd_last_bid,
  output logic                  rd_last_vld,
  input  logic                  wr_en,
  input  logic [ID_W-1:0]       wr_id,
  input  side_e                 wr_side,
  input  logic                  wr_clear,
  input  logic [DATA_WIDTH-1:0] wr_price,
  input  logic                  last_set,
  input  logic                  last_clr,
  input  logic [DATA_WIDTH-1:0] last_ask,
  input  logic [DATA_WIDTH-1:0] last_bid
);

  logic [DATA_WIDTH-1:0] bid_q      [NUM_STOCKS];
  logic [DATA_WIDTH-1:0] bid_d      [NUM_STOCKS];
  logic [DATA_WIDTH-1:0] ask_q      [NUM_STOCKS];
  logic [DATA_WIDTH-1:0] ask_d      [NUM_STOCKS];
  logic [DATA_WIDTH-1:0] last_ask_q [NUM_STOCKS];
  logic [DATA_WIDTH-1:0] last_ask_d [NUM_STOCKS];
  logic [DATA_WIDTH-1:0] last_bid_q [NUM_STOCKS];
  logic [DATA_WIDTH-1:0] last_bid_d [NUM_STOCKS];
  logic [NUM_STOCKS-1:0] bid_vld_q, bid_vld_d;
  logic [NUM_STOCKS-1:0] ask_vld_q, ask_vld_d;
  logic [NUM_STOCKS-1:0] last_vld_q, last_vld_d;

  assign rd_bid      = bid_q[rd_id];
  assign rd_ask      = ask_q[rd_id];
  assign rd_bid_vld  = bid_vld_q[rd_id];
  assign rd_ask_vld  = ask_vld_q[rd_id];
  assign rd_last_ask = last_ask_q[rd_id];
  assign rd_last_bid = last_bid_q[rd_id];
  assign rd_last_vld = last_vld_q[rd_id];

  always_comb begin
    bid_d      = bid_q;
    ask_d      = ask_q;
    last_ask_d = last_ask_q;
    last_bid_d = last_bid_q;
    bid_vld_d  = bid_vld_q;
    ask_vld_d  = ask_vld_q;
    last_vld_d = last_vld_q;
    // A clear only drops the presence flag; the stale price is kept.
    if (wr_en) begin
      if (wr_side == SIDE_ASK) begin
        ask_vld_d[wr_id] = !wr_clear;
        if (!wr_clear) ask_d[wr_id] = wr_price;
      end else begin
        bid_vld_d[wr_id] = !wr_clear;
        if (!wr_clear) bid_d[wr_id] = wr_price;
      end
    end
    if (last_set) begin
      last_ask_d[wr_id] = last_ask;
      last_bid_d[wr_id] = last_bid;
      last_vld_d[wr_id] = 1'b1;
    end else if (last_clr) begin
      last_vld_d[wr_id] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_STOCKS; i++) begin
        bid_q[i]      <= '0;
        ask_q[i]      <= '0;
        last_ask_q[i] <= '0;
        last_bid_q[i] <= '0;
      end
      bid_vld_q  <= '0;
      ask_vld_q  <= '0;
      last_vld_q <= '0;
    end else begin
      bid_q      <= bid_d;
      ask_q      <= ask_d;
      last_ask_q <= last_ask_d;
      last_bid_q <= last_bid_d;
      bid_vld_q  <= bid_vld_d;
      ask_vld_q  <= ask_vld_d;
      last_vld_q <= last_vld_d;
    end
  end

endmodule

// File: rtl/best_price_tracker.sv
// Per-stock best bid/ask tracker emitting complete, uncrossed, changed pairs to the volatility block.
module best_price_tracker
  import hft_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_STOCKS = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_data_valid,
  input  logic [$clog2(NUM_STOCKS)-1:0] i_stock_id,
  input  side_e                         i_side,
  input  logic                          i_clear,
  input  logic [DATA_WIDTH-1:0]         i_price,
  output logic [$clog2(NUM_STOCKS)-1:0] o_stock_id,
  output logic [DATA_WIDTH-1:0]         o_best_ask,
  output logic [DATA_WIDTH-1:0]         o_best_bid,
  output logic                          o_data_valid,
  output logic [CNT_WIDTH-1:0]          o_crossed_count,
  output logic [CNT_WIDTH-1:0]          o_dropped_count
);

  localparam int ID_W = $clog2(NUM_STOCKS);
  localparam logic [ID_W:0] NUM_ID = (ID_W + 1)'(NUM_STOCKS);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic                  id_ok, accept, drop, emit, crossed;
  logic [DATA_WIDTH-1:0] rd_bid, rd_ask, rd_last_ask, rd_last_bid;
  logic                  rd_bid_vld, rd_ask_vld, rd_last_vld;
  logic [DATA_WIDTH-1:0] cand_bid, cand_ask;
  logic                  cand_bid_vld, cand_ask_vld, changed;

  logic [ID_W-1:0]       stock_id_q, stock_id_d;
  logic [DATA_WIDTH-1:0] best_ask_q, best_ask_d;
  logic [DATA_WIDTH-1:0] best_bid_q, best_bid_d;
  logic                  data_valid_q, data_valid_d;
  logic [CNT_WIDTH-1:0]  crossed_cnt_q, crossed_cnt_d;
  logic [CNT_WIDTH-1:0]  dropped_cnt_q, dropped_cnt_d;

  tob_regfile #(
    .NUM_STOCKS(NUM_STOCKS),
    .DATA_WIDTH(DATA_WIDTH),
    .ID_W      (ID_W)
  ) u_regfile (
    .clk        (i_clk),
    .rst        (i_reset),
    .rd_id      (i_stock_id),
    .rd_bid     (rd_bid),
    .rd_ask     (rd_ask),
    .rd_bid_vld (rd_bid_vld),
    .rd_ask_vld (rd_ask_vld),
    .rd_last_ask(rd_last_ask),
    .rd_last_bid(rd_last_bid),
    .rd_last_vld(rd_last_vld),
    .wr_en      (accept),
    .wr_id      (i_stock_id),
    .wr_side    (i_side),
    .wr_clear   (i_clear),
    .wr_price   (i_price),
    .last_set   (emit),
    .last_clr   (accept && i_clear),
    .last_ask   (cand_ask),
    .last_bid   (cand_bid)
  );

  // Candidate book state is the stored entry with this cycle's update merged in.
  always_comb begin
    id_ok        = {1'b0, i_stock_id} < NUM_ID;
    accept       = i_data_valid && id_ok && (i_clear || (i_price != '0));
    drop         = i_data_valid && !accept;
    cand_bid     = rd_bid;
    cand_ask     = rd_ask;
    cand_bid_vld = rd_bid_vld;
    cand_ask_vld = rd_ask_vld;
    if (accept) begin
      if (i_side == SIDE_ASK) begin
        cand_ask_vld = !i_clear;
        if (!i_clear) cand_ask = i_price;
      end else begin
        cand_bid_vld = !i_clear;
        if (!i_clear) cand_bid = i_price;
      end
    end
    changed = !rd_last_vld || (cand_ask != rd_last_ask) || (cand_bid != rd_last_bid);
    emit    = accept && !i_clear && cand_bid_vld && cand_ask_vld && (cand_ask > cand_bid) && changed;
    crossed = accept && !i_clear && cand_bid_vld && cand_ask_vld && (cand_ask <= cand_bid);
  end

  always_comb begin
    data_valid_d  = emit;
    stock_id_d    = emit ? i_stock_id : stock_id_q;
    best_ask_d    = emit ? cand_ask : best_ask_q;
    best_bid_d    = emit ? cand_bid : best_bid_q;
    crossed_cnt_d = crossed ? sat_inc(crossed_cnt_q) : crossed_cnt_q;
    dropped_cnt_d = drop ? sat_inc(dropped_cnt_q) : dropped_cnt_q;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      data_valid_q  <= 1'b0;
      stock_id_q    <= '0;
      best_ask_q    <= '0;
      best_bid_q    <= '0;
      crossed_cnt_q <= '0;
      dropped_cnt_q <= '0;
    end else begin
      data_valid_q  <= data_valid_d;
      stock_id_q    <= stock_id_d;
      best_ask_q    <= best_ask_d;
      best_bid_q    <= best_bid_d;
      crossed_cnt_q <= crossed_cnt_d;
      dropped_cnt_q <= dropped_cnt_d;
    end
  end

  assign o_data_valid    = data_valid_q;
  assign o_stock_id      = stock_id_q;
  assign o_best_ask      = best_ask_q;
  assign o_best_bid      = best_bid_q;
  assign o_crossed_count = crossed_cnt_q;
  assign o_dropped_count = dropped_cnt_q;

endmodule

// File: tb/tb_best_price_tracker.sv
// Directed bench for best_price_tracker with immediate-assertion checks.
module tb_best_price_tracker;
  import hft_pkg::*;

  logic        i_clk;
  logic        i_reset;
  logic        i_data_valid;
  logic [1:0]  i_stock_id;
  side_e       i_side;
  logic        i_clear;
  logic [31:0] i_price;
  logic [1:0]  o_stock_id;
  logic [31:0] o_best_ask;
  logic [31:0] o_best_bid;
  logic        o_data_valid;
  logic [15:0] o_crossed_count;
  logic [15:0] o_dropped_count;

  int checks = 0;
  int errors = 0;

  best_price_tracker #(
    .DATA_WIDTH(32),
    .NUM_STOCKS(4),
    .CNT_WIDTH (16)
  ) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_data_valid   (i_data_valid),
    .i_stock_id     (i_stock_id),
    .i_side         (i_side),
    .i_clear        (i_clear),
    .i_price        (i_price),
    .o_stock_id     (o_stock_id),
    .o_best_ask     (o_best_ask),
    .o_best_bid     (o_best_bid),
    .o_data_valid   (o_data_valid),
    .o_crossed_count(o_crossed_count),
    .o_dropped_count(o_dropped_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one update for the coming edge, then release the strobe just after it.
  task automatic upd(input logic [1:0] id, input side_e s, input logic clr, input logic [31:0] p);
    i_data_valid = 1'b1;
    i_stock_id   = id;
    i_side       = s;
    i_clear      = clr;
    i_price      = p;
    @(posedge i_clk);
    #1;
    i_data_valid = 1'b0;
  endtask

  task automatic idle();
    i_data_valid = 1'b0;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_pair(input string tag, input logic [1:0] id, input logic [31:0] ask, input logic [31:0] bid);
    chk({tag, "_vld"}, o_data_valid, 1);
    chk({tag, "_id"},  o_stock_id, id);
    chk({tag, "_ask"}, o_best_ask, ask);
    chk({tag, "_bid"}, o_best_bid, bid);
  endtask

  initial begin
    i_reset      = 1'b1;
    i_data_valid = 1'b0;
    i_stock_id   = '0;
    i_side       = SIDE_BID;
    i_clear      = 1'b0;
    i_price      = '0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_vld", o_data_valid, 0);
    chk("rst_id", o_stock_id, 0);
    chk("rst_ask", o_best_ask, 0);
    chk("rst_bid", o_best_bid, 0);
    chk("rst_xcnt", o_crossed_count, 0);
    chk("rst_dcnt", o_dropped_count, 0);
    i_reset = 1'b0;
    idle();

    // First complete pair on stock 1
    upd(2'd1, SIDE_BID, 1'b0, 32'd100);
    chk("t1_bid_only", o_data_valid, 0);
    upd(2'd1, SIDE_ASK, 1'b0, 32'd105);
    chk_pair("t1_pair", 2'd1, 32'd105, 32'd100);
    idle();
    chk("t1_pulse_end", o_data_valid, 0);
    chk("t1_hold_ask", o_best_ask, 105);
    chk("t1_hold_bid", o_best_bid, 100);

    // Unchanged pair is suppressed, changed ask emits
    upd(2'd1, SIDE_ASK, 1'b0, 32'd105);
    chk("t2_repeat", o_data_valid, 0);
    upd(2'd1, SIDE_ASK, 1'b0, 32'd104);
    chk_pair("t2_pair", 2'd1, 32'd104, 32'd100);

    // Locked book counts as crossed; recovery to last pair stays silent
    upd(2'd2, SIDE_BID, 1'b0, 32'd200);
    chk("t3_bid_only", o_data_valid, 0);
    upd(2'd2, SIDE_ASK, 1'b0, 32'd200);
    chk("t3_locked_vld", o_data_valid, 0);
    chk("t3_locked_cnt", o_crossed_count, 1);
    upd(2'd2, SIDE_ASK, 1'b0, 32'd201);
    chk_pair("t3_pair", 2'd2, 32'd201, 32'd200);
    upd(2'd2, SIDE_ASK, 1'b0, 32'd199);
    chk("t3_cross_vld", o_data_valid, 0);
    chk("t3_cross_cnt", o_crossed_count, 2);
    upd(2'd2, SIDE_ASK, 1'b0, 32'd201);
    chk("t3_recover", o_data_valid, 0);

    // Two different stocks completing on consecutive cycles
    upd(2'd0, SIDE_BID, 1'b0, 32'd50);
    upd(2'd3, SIDE_BID, 1'b0, 32'd300);
    chk("t4_prep", o_data_valid, 0);
    upd(2'd0, SIDE_ASK, 1'b0, 32'd60);
    chk_pair("t4_s0", 2'd0, 32'd60, 32'd50);
    upd(2'd3, SIDE_ASK, 1'b0, 32'd310);
    chk_pair("t4_s3", 2'd3, 32'd310, 32'd300);

    // Clear invalidates last pair so an equal pair re-emits
    upd(2'd1, SIDE_ASK, 1'b1, 32'd999);
    chk("t5_clear", o_data_valid, 0);
    chk("t5_clear_hold", o_best_ask, 310);
    upd(2'd1, SIDE_ASK, 1'b0, 32'd104);
    chk_pair("t5_reemit", 2'd1, 32'd104, 32'd100);

    // Zero price without clear is dropped and leaves the book alone
    upd(2'd1, SIDE_BID, 1'b0, 32'd0);
    chk("t6_drop_vld", o_data_valid, 0);
    chk("t6_drop_cnt", o_dropped_count, 1);
    upd(2'd1, SIDE_ASK, 1'b0, 32'd103);
    chk_pair("t6_after_drop", 2'd1, 32'd103, 32'd100);
    chk("t6_xcnt_same", o_crossed_count, 2);

    // Dropped counter saturates at all-ones
    i_data_valid = 1'b1;
    i_stock_id   = 2'd0;
    i_side       = SIDE_ASK;
    i_clear      = 1'b0;
    i_price      = 32'd0;
    repeat (65534) @(posedge i_clk);
    #1;
    chk("sat_below", o_dropped_count, 16'hFFFF);
    @(posedge i_clk);
    #1;
    chk("sat_hold", o_dropped_count, 16'hFFFF);
    i_data_valid = 1'b0;
    idle();

    // Reset with an emit pending: stock 1 ask 102 would complete a pair
    i_data_valid = 1'b1;
    i_stock_id   = 2'd1;
    i_side       = SIDE_ASK;
    i_clear      = 1'b0;
    i_price      = 32'd102;
    #2;
    i_reset = 1'b1;
    #1;
    chk("mid_rst_vld", o_data_valid, 0);
    chk("mid_rst_ask", o_best_ask, 0);
    chk("mid_rst_dcnt", o_dropped_count, 0);
    chk("mid_rst_xcnt", o_crossed_count, 0);
    @(posedge i_clk);
    #1;
    chk("mid_rst_edge", o_data_valid, 0);
    i_data_valid = 1'b0;
    i_reset      = 1'b0;
    idle();
    upd(2'd1, SIDE_ASK, 1'b0, 32'd105);
    chk("post_rst_single", o_data_valid, 0);
    upd(2'd1, SIDE_BID, 1'b0, 32'd101);
    chk_pair("post_rst_pair", 2'd1, 32'd105, 32'd101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
